burst_read_bram: RTL and testbench

AXI4 read master that fetches a single beat or an INCR burst from the BRAM slave and hands the words out on a valid/ready stream. It is the read-side counterpart of the single-beat BRAM write master and is triggered the same way, by a rising edge on `start`. It sits between the sampler/control logic and the AXI BRAM controller in the PL.

---
 rtl/bram_axi_pkg.sv | 40 ++++
 rtl/start_edge_detect.sv | 37 +++
 rtl/burst_read_bram.sv | 132 +++++++++++++
 tb/tb_burst_read_bram.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_axi_pkg.sv
// Shared definitions for the BRAM AXI masters: burst/response/size encodings,
// the 4 KB boundary, FSM state types and the 4 KB burst-length clamp.
package bram_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [2:0] SIZE_4B     = 3'd2;

    localparam logic [12:0] BOUNDARY_4K = 13'd4096;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } rd_state_t;

    typedef enum logic [1:0] {
        ZERO,
        EDGE,
        ONE
    } edge_state_t;

    // Limit a burst so it never crosses a 4 KB page: beats left in the page minus one.
    function automatic logic [7:0] clamp_len(input logic [11:0] offs, input logic [7:0] len);
        logic [12:0] room;
        logic [12:0] lim;
        logic [12:0] len13;
        logic [12:0] res;
        room  = (BOUNDARY_4K - {1'b0, offs}) >> 2;
        lim   = room - 13'd1;
        len13 = {5'd0, len};
        res   = (len13 > lim) ? lim : len13;
        return 8'(res);
    endfunction

endpackage

// File: rtl/start_edge_detect.sv
// Rising-edge detector on a level start input; tick is high for exactly one
// cycle, the cycle after start is first sampled high.
//  state | meaning
//  ZERO  | start low, waiting for it to rise
//  EDGE  | start just sampled high, tick asserted
//  ONE   | start still high, waiting for it to fall
module start_edge_detect
    import bram_axi_pkg::*;
(
    input  logic aclk,
    input  logic rst,
    input  logic start,
    output logic tick
);

    edge_state_t state, state_nxt;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) state <= ZERO;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        case (state)
            ZERO: if (start) state_nxt = EDGE;
            EDGE: begin
                tick      = 1'b1;
                state_nxt = start ? ONE : ZERO;
            end
            ONE:  if (!start) state_nxt = ZERO;
            default: state_nxt = ZERO;
        endcase
    end

endmodule

// File: rtl/burst_read_bram.sv
// AXI4 read master: one INCR burst per start edge, beats handed out through a
// one-entry holding register. Optional rlast checking: BURST_READ_RLAST_CHECK_EN.
//  state | meaning
//  IDLE  | waiting for a start edge
//  ADDR  | arvalid held until arready
//  DATA  | accepting R beats until beat_cnt reaches arlen
//  DONE  | one-cycle done pulse
module burst_read_bram
    import bram_axi_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    rd_state_t  state, state_nxt;
    logic       tick;
    logic       beat;
    logic       last_beat;
    logic       resp_bad;
    logic       rlast_bad;
    logic [8:0] beat_cnt;

    start_edge_detect u_start_edge (
        .aclk  (aclk),
        .rst   (rst),
        .start (start),
        .tick  (tick)
    );

    assign arsize    = SIZE_4B;
    assign arburst   = BURST_INCR;
    assign beat      = rvalid && rready;
    assign last_beat = (beat_cnt == {1'b0, arlen});
    assign resp_bad  = (rresp != RESP_OKAY);

`ifdef BURST_READ_RLAST_CHECK_EN
    assign rlast_bad = (rlast != last_beat);
`else
    assign rlast_bad = rlast & 1'b0;
`endif

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // rready is recomputed locally in DATA to keep the beat/next-state path acyclic.
    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick) state_nxt = ADDR;
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = DATA;
            end
            DATA: begin
                rready = !dout_valid || dout_ready;
                if (rvalid && (!dout_valid || dout_ready) && last_beat) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            araddr   <= '0;
            arlen    <= '0;
            err      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && tick) begin
                araddr   <= addr;
                arlen    <= clamp_len(addr[11:0], len);
                err      <= 1'b0;
                beat_cnt <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 9'd1;
                if (resp_bad || rlast_bad) err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (beat) begin
                dout       <= rdata;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_burst_read_bram.sv
// Directed self-checking bench for burst_read_bram with an inline AXI R-slave
// and stream-consumer model.
module tb_burst_read_bram;

    logic        aclk = 1'b0;
    logic        rst;
    logic        start;
    logic [14:0] addr;
    logic [7:0]  len;
    logic [14:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    burst_read_bram #(.ADDR_W(15), .DATA_W(32)) dut (
        .aclk       (aclk),
        .rst        (rst),
        .start      (start),
        .addr       (addr),
        .len        (len),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_burst(input logic [14:0] a, input logic [7:0] l, input logic [7:0] exp_len,
                             input logic [31:0] base, input int err_beat, input int rlast_beat,
                             input bit toggle, input int ar_delay, input bit retrig);
        int sent;
        int got;
        int budget;
        bit in_data;
        bit dv_m;
        bit err_m;
        bit done_exp;
        bit ph;
        bit exp_rr;
        bit acc;
        bit pop;
        start = 1'b0; rvalid = 1'b0; arready = 1'b0; dout_ready = 1'b1;
        step();
        addr = a; len = l; start = 1'b1;
        step();
        chk("edge_busy", busy, 0);
        arready = (ar_delay == 0);
        step();
        chk("addr_arvalid", arvalid, 1);
        chk("addr_araddr", araddr, a);
        chk("addr_arlen", arlen, exp_len);
        chk("addr_arsize", arsize, 2);
        chk("addr_arburst", arburst, 1);
        chk("addr_err_clr", err, 0);
        chk("addr_rready", rready, 0);
        for (int i = 0; i < ar_delay; i++) begin
            if (retrig && i == 0) start = 1'b0;
            if (retrig && i == 1) start = 1'b1;
            step();
            chk("hold_arvalid", arvalid, 1);
            chk("hold_araddr", araddr, a);
            chk("hold_arlen", arlen, exp_len);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("data_arvalid", arvalid, 0);
        sent = 0; got = 0; budget = 0;
        in_data = 1; dv_m = 0; err_m = 0; done_exp = 0; ph = 0;
        while (budget < 200) begin
            if (!in_data && !done_exp && !dv_m && got == int'(exp_len) + 1) break;
            rvalid = in_data;
            rdata  = base + 32'(sent);
            rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
            rlast  = (rlast_beat >= 0) ? (sent == rlast_beat) : (sent == int'(exp_len));
            dout_ready = toggle ? ph : 1'b1;
            ph = !ph;
            #1;
            exp_rr = in_data && (!dv_m || dout_ready);
            chk("rready", rready, exp_rr);
            acc = rvalid && exp_rr;
            pop = dv_m && dout_ready;
            if (dv_m) chk("dout", dout, base + 32'(got));
            if (pop) got++;
            step();
            done_exp = 0;
            if (acc) begin
                if (rresp != 2'b00) err_m = 1;
`ifdef BURST_READ_RLAST_CHECK_EN
                if (rlast != (sent == int'(exp_len))) err_m = 1;
`endif
                if (sent == int'(exp_len)) begin
                    in_data  = 0;
                    done_exp = 1;
                end
                sent++;
                dv_m = 1;
            end else if (pop) begin
                dv_m = 0;
            end
            chk("dout_valid", dout_valid, dv_m);
            chk("done", done, done_exp);
            chk("err", err, err_m);
            chk("busy", busy, in_data || done_exp);
            budget++;
        end
        if (budget >= 200) chk("burst_timeout", 0, 1);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; dout_ready = 1'b1;
        chk("words_out", got, int'(exp_len) + 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_arvalid", arvalid, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; len = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0; dout_ready = 1'b1;
        #2;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_dout", dout, 0);
        step();
        step();
        rst = 1'b0;

        // single read, word 0xDEADBEEF
        run_burst(15'h0010, 8'd0, 8'd0, 32'hDEADBEEF, -1, -1, 0, 0, 0);
        // burst of 8 with toggling back-pressure
        run_burst(15'h0100, 8'd7, 8'd7, 32'h1000_0000, -1, -1, 1, 0, 0);
        // 4 KB clamp: 0x0FF8 leaves 2 words
        run_burst(15'h0FF8, 8'd15, 8'd1, 32'h2000_0000, -1, -1, 0, 0, 0);
        // SLVERR on beat 2 of 4
        run_burst(15'h0200, 8'd3, 8'd3, 32'h3000_0000, 1, -1, 0, 0, 0);
        // retrigger while waiting on a stalled AR; also clears the previous err
        run_burst(15'h0300, 8'd2, 8'd2, 32'h4000_0000, -1, -1, 0, 5, 1);
        // early rlast on beat 1 of 4: flagged only when rlast checking is built in
        run_burst(15'h0400, 8'd3, 8'd3, 32'h5000_0000, -1, 0, 0, 0, 0);
        // clamp at an interior page offset: 0x1F00 leaves 64 words
        run_burst(15'h1F00, 8'd200, 8'd63, 32'h6000_0000, -1, -1, 0, 0, 0);

        // reset in the middle of a burst of 8 after 3 beats
        start = 1'b0; step();
        addr = 15'h0040; len = 8'd7; start = 1'b1;
        step();
        arready = 1'b1;
        step();
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_0000; dout_ready = 1'b1;
        step(); step(); step();
        chk("mid_dout_valid", dout_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_arvalid", arvalid, 0);
        chk("arst_rready", rready, 0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_busy", busy, 0);
        chk("arst_araddr", araddr, 0);
        chk("arst_arlen", arlen, 0);
        chk("arst_dout", dout, 0);
        rvalid = 1'b0; start = 1'b0;
        step();
        rst = 1'b0;
        run_burst(15'h0080, 8'd1, 8'd1, 32'h7000_0000, -1, -1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
